// File: rtl/pipe_dispatch_fifo.sv
// Tagged-pipe input dispatcher: routes each {tag, payload} message into one of
// NUM_METHODS independent FIFOs, each of which drives its own method invocation.
module pipe_dispatch_fifo #(
  parameter int NUM_METHODS = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              pipe_enq__ENA,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0]   pipe_enq_v,
  output logic                              pipe_enq__RDY,
  output logic [NUM_METHODS-1:0]            out__ENA,
  output logic [NUM_METHODS*DATA_WIDTH-1:0] out_v,
  input  logic [NUM_METHODS-1:0]            out__RDY,
  output logic [15:0]                       drop_count
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a transfer happens on a rising edge where ENA=1 and RDY=1.
  // RDY never depends on the same-side ENA; producers raise ENA only while
  // RDY=1 and hold the argument stable for that cycle.

  logic [TAG_WIDTH-1:0]   tag;
  logic [DATA_WIDTH-1:0]  payload;
  logic [NUM_METHODS-1:0] hit;
  logic [NUM_METHODS-1:0] full;
  logic [NUM_METHODS-1:0] empty;
  logic                   tag_valid;
  logic                   enq_fire;

  assign tag     = pipe_enq_v[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign payload = pipe_enq_v[DATA_WIDTH-1:0];

  // One-hot tag decode: tag t selects channel t-1; everything else is invalid.
  for (genvar i = 0; i < NUM_METHODS; i++) begin : g_decode
    assign hit[i] = (tag == TAG_WIDTH'(i + 1));
  end

  assign tag_valid = |hit;

  // Guard looks only at registered full flags, so callee readiness never
  // reaches the enqueue guard combinationally.
  assign pipe_enq__RDY = tag_valid ? ~|(hit & full) : 1'b1;
  assign enq_fire      = pipe_enq__ENA && pipe_enq__RDY;

  for (genvar i = 0; i < NUM_METHODS; i++) begin : g_chan
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push;
    logic                  pop;

    assign empty[i] = (wr_ptr == rd_ptr);
    assign full[i]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push        = enq_fire && hit[i] && !full[i];
    assign pop         = !empty[i] && out__RDY[i];
    assign out__ENA[i] = pop;

    // Head is forced to zero while empty so idle channels present a clean bus.
    assign out_v[i*DATA_WIDTH +: DATA_WIDTH] =
      empty[i] ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end

    // Storage needs no reset: entries are only observable between push and pop.
    always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr[AW-1:0]] <= payload;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_count <= '0;
    end else if (enq_fire && !tag_valid && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_dispatch_fifo.sv
// Directed bench for pipe_dispatch_fifo: issued messages push expected payloads
// into per-channel queues; a negedge monitor pops and compares every invoke.
module tb_pipe_dispatch_fifo;

  localparam int NM = 4;
  localparam int TW = 8;
  localparam int DW = 64;

  logic               CLK;
  logic               RST;
  logic               pipe_enq__ENA;
  logic [TW+DW-1:0]   pipe_enq_v;
  logic               pipe_enq__RDY;
  logic [NM-1:0]      out__ENA;
  logic [NM*DW-1:0]   out_v;
  logic [NM-1:0]      out__RDY;
  logic [15:0]        drop_count;

  logic [DW-1:0] exp_q[NM][$];
  int n_checks;
  int n_pass;

  pipe_dispatch_fifo #(
    .NUM_METHODS(NM), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .DEPTH(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .pipe_enq__ENA(pipe_enq__ENA),
    .pipe_enq_v(pipe_enq_v),
    .pipe_enq__RDY(pipe_enq__RDY),
    .out__ENA(out__ENA),
    .out_v(out_v),
    .out__RDY(out__RDY),
    .drop_count(drop_count)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver: called at posedge+1, returns at the following posedge+1.
  task automatic enq(input logic [TW-1:0] tag, input logic [DW-1:0] d);
    pipe_enq__ENA = 1'b1;
    pipe_enq_v    = {tag, d};
    #1 check("enq_rdy", {63'd0, pipe_enq__RDY}, 64'd1);
    @(posedge CLK);
    if (tag >= 1 && tag <= NM) exp_q[tag-1].push_back(d);
    #1 pipe_enq__ENA = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < NM; i++) exp_q[i].delete();
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        for (int i = 0; i < NM; i++) begin
          if (out__ENA[i]) begin
            if (exp_q[i].size() == 0) begin
              check($sformatf("unexpected_ena_ch%0d", i), out_v[i*DW +: DW], 64'hDEAD_0000_0000_DEAD);
            end else begin
              check($sformatf("payload_ch%0d", i), out_v[i*DW +: DW], exp_q[i].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int stale;
    n_checks      = 0;
    n_pass        = 0;
    RST           = 1'b1;
    pipe_enq__ENA = 1'b0;
    pipe_enq_v    = '0;
    out__RDY      = '0;

    // Reset state
    #3;
    check("rst_rdy",  {63'd0, pipe_enq__RDY}, 64'd1);
    check("rst_ena",  {60'd0, out__ENA}, 64'd0);
    check("rst_drop", {48'd0, drop_count}, 64'd0);
    check("rst_outv", out_v[DW-1:0] | out_v[2*DW-1:DW] | out_v[3*DW-1:2*DW] | out_v[4*DW-1:3*DW], 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Test 1: single message, no bypass, one-cycle latency
    out__RDY      = 4'b1111;
    pipe_enq__ENA = 1'b1;
    pipe_enq_v    = {8'd1, 64'hA5};
    @(negedge CLK);
    check("no_bypass_ena", {60'd0, out__ENA}, 64'd0);
    @(posedge CLK);
    exp_q[0].push_back(64'hA5);
    #1 pipe_enq__ENA = 1'b0;
    @(negedge CLK);
    check("t1_ena", {60'd0, out__ENA}, 64'h1);
    check("t1_outv", out_v[DW-1:0], 64'hA5);
    @(negedge CLK);
    check("t1_empty_ena", {60'd0, out__ENA}, 64'd0);
    tick();

    // Test 2: fill channel 1 with its callee stalled; channel 2 unaffected
    out__RDY = 4'b1101;
    for (int k = 1; k <= 4; k++) enq(8'd2, 64'(k));
    pipe_enq_v = {8'd2, 64'd0};
    #1 check("t2_rdy_full", {63'd0, pipe_enq__RDY}, 64'd0);
    enq(8'd3, 64'h33);
    @(negedge CLK);
    check("t2_ch2_ena", {60'd0, out__ENA}, 64'b0100);
    tick();

    // Test 3: release channel 1; RDY reopens only the cycle after first pop
    out__RDY   = 4'b1111;
    pipe_enq_v = {8'd2, 64'd0};
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check($sformatf("t3_ena1_%0d", k), {63'd0, out__ENA[1]}, 64'd1);
      check($sformatf("t3_rdy_%0d", k), {63'd0, pipe_enq__RDY}, (k == 0) ? 64'd0 : 64'd1);
      tick();
    end
    @(negedge CLK);
    check("t3_drained_ena", {60'd0, out__ENA}, 64'd0);
    check("t3_queue_empty", 64'(exp_q[1].size()), 64'd0);
    tick();

    // Test 4: invalid tags are dropped and counted
    enq(8'd0, 64'h11);
    enq(8'd5, 64'h22);
    @(negedge CLK);
    check("t4_drop", {48'd0, drop_count}, 64'd2);
    check("t4_ena", {60'd0, out__ENA}, 64'd0);
    tick();

    // Test 5: saturate drop_count
    pipe_enq__ENA = 1'b1;
    pipe_enq_v    = {8'hFF, 64'h0};
    repeat (65533) @(posedge CLK);
    #1 pipe_enq__ENA = 1'b0;
    @(negedge CLK);
    check("t5_drop_max", {48'd0, drop_count}, 64'hFFFF);
    tick();
    enq(8'd0, 64'h0);
    @(negedge CLK);
    check("t5_drop_sat", {48'd0, drop_count}, 64'hFFFF);
    tick();

    // Test 6: reset mid-operation with two entries buffered per channel
    out__RDY = 4'b0000;
    for (int c = 0; c < NM; c++)
      for (int k = 0; k < 2; k++) enq(8'(c + 1), {32'(c), 32'(k + 100)});
    @(negedge CLK);
    check("t6_held_ena", {60'd0, out__ENA}, 64'd0);
    tick();
    out__RDY = 4'b1111;
    #1 check("t6_pre_rst_ena", {60'd0, out__ENA}, 64'hF);
    #1 RST = 1'b1;
    #1;
    check("t6_rst_ena",  {60'd0, out__ENA}, 64'd0);
    check("t6_rst_drop", {48'd0, drop_count}, 64'd0);
    check("t6_rst_outv", out_v[DW-1:0] | out_v[2*DW-1:DW] | out_v[3*DW-1:2*DW] | out_v[4*DW-1:3*DW], 64'd0);
    flush();
    @(negedge CLK);
    RST = 1'b0;
    stale = 0;
    repeat (10) begin
      @(negedge CLK);
      if (out__ENA != '0) stale++;
    end
    check("t6_no_stale", 64'(stale), 64'd0);
    pipe_enq_v = {8'd1, 64'd0};
    #1 check("t6_post_rdy", {63'd0, pipe_enq__RDY}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_dispatch_fifo.md
Name: pipe_dispatch_fifo

Overview:
- Tagged-pipe input dispatcher, next generation of the single-method pipe-input demux.
- Accepts one tagged message per cycle on an ENA/RDY pipe.enq method and routes it by tag into one of NUM_METHODS per-method FIFOs.
- Each FIFO independently drives its own method invocation, so a stalled method never blocks the others.
- Sits between the transport pipe and the user-level indication/request interface.

Parameters:
- NUM_METHODS, 4: number of method channels; valid tags are 1..NUM_METHODS.
- TAG_WIDTH, 8: width of the tag field in pipe.enq$v.
- DATA_WIDTH, 64: payload width per message.
- DEPTH, 4: entries per channel FIFO; power of two, minimum 2.

Ports:
- CLK  in  1  clock; all state rising-edge.
- RST  in  1  asynchronous, active-high reset.
- pipe$enq__ENA  in  1  enqueue strobe; driven only while pipe$enq__RDY=1.
- pipe$enq$v  in  TAG_WIDTH+DATA_WIDTH  {tag, payload}; tag occupies the MSBs.
- pipe$enq__RDY  out  1  enqueue guard.
- out__ENA  out  NUM_METHODS  per-method invoke strobe.
- out$v  out  NUM_METHODS*DATA_WIDTH  per-method payload; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out__RDY  in  NUM_METHODS  per-method callee guard.
- drop_count  out  16  count of messages discarded for invalid tag.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all FIFOs empty;
  - out__ENA = 0;
  - drop_count = 0;
  - out$v = 0;
  - pipe$enq__RDY follows the guard below, evaluated with all FIFOs empty.
- Tag decode:
  - tag t in 1..NUM_METHODS maps to channel c = t-1;
  - any other tag (0 or > NUM_METHODS) is invalid.
- Guard (argument-dependent):
  - pipe$enq__RDY = !full[c] when the tag is valid;
  - pipe$enq__RDY = 1 when the tag is invalid.
  - full[] is registered state only; there is no combinational path from out__RDY to pipe$enq__RDY.
- Enqueue when ENA=1 and the tag is valid: payload is written into FIFO c at the next edge.
- Enqueue when ENA=1 and the tag is invalid:
  - payload is discarded;
  - drop_count increments, saturating at 16'hFFFF.
- Dequeue side, per channel i:
  - out__ENA[i] = !empty[i] && out__RDY[i];
  - out$v slice i = head entry of FIFO i, valid whenever !empty[i].
  - The FIFO pops at the edge where out__ENA[i]=1.
- Latency: a message enqueued at edge N is visible at the head (out__ENA possible) from edge N+1. There is no same-cycle bypass.
- Full FIFO:
  - a simultaneous pop in the same cycle does not make RDY=1 that cycle;
  - the freed slot is usable from the next cycle.
- Empty FIFO: out__ENA[i]=0 regardless of out__RDY[i].
- Simultaneous push and pop on one non-full, non-empty FIFO: both occur; occupancy is unchanged.
- Pointers: log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full/empty derived from the MSB difference.
- Channels are fully independent; ordering is preserved within a channel only.
- Reset asserted mid-operation: all in-flight and buffered data is lost; outputs return to reset values immediately (async).
- Every enqueue is accounted for: one message per ENA results in either a FIFO write or a drop_count increment.

Test Plan:
- Reset, then enq tag=1 payload=0xA5, out__RDY=all 1 -> out__ENA=4'b0001 one cycle after the enq edge; out$v[63:0]=0xA5; FIFO 0 empties.
- out__RDY[1]=0; enq tag=2 ×4 (payloads 1..4) -> pipe$enq__RDY=0 for tag 2 after the 4th; a tag=3 enq is still accepted and emerges on channel 2 with no blocking.
- Raise out__RDY[1] with FIFO 1 full and tag 2 presented -> pops 1,2,3,4 in order on consecutive cycles; RDY for tag 2 returns to 1 the cycle after the first pop, not the same cycle.
- Enq tag=0, then tag=5 (NUM_METHODS=4) -> RDY=1 both cycles; drop_count=2; no out__ENA asserted.
- Preload drop_count to 0xFFFF via repeated invalid tags -> stays at 0xFFFF on the next invalid enq.
- Assert RST mid-burst with FIFOs holding 2 entries each -> out__ENA=0 and drop_count=0 immediately; after release, no stale data is emitted.
